// File: rtl/systolic_output_drain.sv
// systolic_output_drain: reads a finished tile row by row, requantizes int32 lanes to int8,
// and streams packed rows through a credit-limited FIFO with valid/ready backpressure.
module systolic_output_drain #(
    parameter int DATAWIDTH        = 8,
    parameter int DATAWIDTH_output = 32,
    parameter int N_SIZE           = 32,
    parameter int BUS_WIDTH        = N_SIZE * DATAWIDTH,
    parameter int ADDR_WIDTH       = 10,
    parameter int SCALE_WIDTH      = 16,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [ADDR_WIDTH-1:0]              num_rows,
    input  logic [SCALE_WIDTH-1:0]             scale,
    input  logic [4:0]                         shift,
    output logic [ADDR_WIDTH-1:0]              rd_addr_outbuffer,
    input  logic [DATAWIDTH_output*N_SIZE-1:0] rd_data_outbuffer,
    output logic [BUS_WIDTH-1:0]               out_data,
    output logic                               out_valid,
    output logic                               out_last,
    input  logic                               out_ready,
    output logic                               busy,
    output logic                               done
);
    localparam int PW    = DATAWIDTH_output + SCALE_WIDTH + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic signed [PW-1:0] QMAX = PW'((1 << (DATAWIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] QMIN = ~QMAX;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0]  rows_r, next_addr, issue_addr;
    logic [SCALE_WIDTH-1:0] scale_r;
    logic [4:0]             shift_r;
    logic                   a_v, a_last, d_v, d_last, m_v, m_last;
    logic signed [PW-1:0]   m_p [N_SIZE];
    logic signed [PW-1:0]   rnd;
    logic [BUS_WIDTH-1:0]   r_row;
    logic [BUS_WIDTH-1:0]   mem_d [FIFO_DEPTH];
    logic                   mem_l [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       fifo_count;
    logic [1:0]             inflight;
    logic                   pop, issue, issue_last, credit, zero_start, done_r;

    assign inflight  = {1'b0, a_v} + {1'b0, d_v} + {1'b0, m_v};
    assign out_valid = fifo_count != '0;
    assign out_data  = out_valid ? mem_d[rd_ptr] : '0;
    assign out_last  = out_valid && mem_l[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign done      = done_r || (pop && out_last);
    assign busy      = state != IDLE;
    // A beat leaving this cycle frees its slot for the read issued on the same edge.
    assign credit    = 32'(fifo_count) + 32'(inflight) - 32'(pop) < 32'(FIFO_DEPTH);
    assign rnd       = (PW'(1) << shift_r) >> 1;

    always_comb begin
        state_nx   = state;
        issue      = 1'b0;
        zero_start = 1'b0;
        issue_addr = (state == IDLE) ? '0 : next_addr;
        issue_last = (state == IDLE) ? (num_rows == ADDR_WIDTH'(1)) : (next_addr == rows_r - ADDR_WIDTH'(1));
        case (state)
            IDLE: if (start) begin
                zero_start = num_rows == '0;
                issue      = num_rows != '0;
                state_nx   = (num_rows == '0) ? IDLE : issue_last ? DRAIN : ISSUE;
            end
            ISSUE: begin
                issue    = credit;
                state_nx = (credit && issue_last) ? DRAIN : ISSUE;
            end
            DRAIN:   state_nx = (pop && out_last) ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            rows_r            <= '0;
            scale_r           <= '0;
            shift_r           <= '0;
            next_addr         <= '0;
            rd_addr_outbuffer <= '0;
            {a_v, a_last, d_v, d_last, m_v, m_last} <= '0;
            done_r            <= 1'b0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            fifo_count        <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                rows_r  <= num_rows;
                scale_r <= scale;
                shift_r <= shift;
            end
            if (issue) begin
                rd_addr_outbuffer <= issue_addr;
                next_addr         <= issue_addr + ADDR_WIDTH'(1);
            end
            a_v    <= issue;
            a_last <= issue && issue_last;
            d_v    <= a_v;
            d_last <= a_last;
            m_v    <= d_v;
            m_last <= d_last;
            done_r <= zero_start;
            if (m_v) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(m_v) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SIZE; i++)
            m_p[i] <= PW'($signed(rd_data_outbuffer[i*DATAWIDTH_output +: DATAWIDTH_output])) * PW'($signed({1'b0, scale_r}));
        if (m_v) begin
            mem_d[wr_ptr] <= r_row;
            mem_l[wr_ptr] <= m_last;
        end
    end

    for (genvar k = 0; k < N_SIZE; k++) begin : g_lane
        logic signed [PW-1:0] q;
        assign q = (m_p[k] + rnd) >>> shift_r;
        assign r_row[k*DATAWIDTH +: DATAWIDTH] = (q > QMAX) ? QMAX[DATAWIDTH-1:0] : (q < QMIN) ? QMIN[DATAWIDTH-1:0] : q[DATAWIDTH-1:0];
    end
endmodule

// File: tb/tb_systolic_output_drain.sv
// tb_systolic_output_drain: directed checks of timing, requantization, backpressure,
// zero-row tiles, mid-drain reset and ignored start for systolic_output_drain.
module tb_systolic_output_drain;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [9:0]    num_rows = '0;
    logic [15:0]   scale = '0;
    logic [4:0]    shift = '0;
    logic [9:0]    rd_addr_outbuffer;
    logic [1023:0] rd_data_outbuffer = '0;
    logic [255:0]  out_data;
    logic          out_valid, out_last, busy, done;
    logic          out_ready = 1'b0;

    logic [1023:0] bmem [16];
    logic [255:0]  got [16];
    logic          got_last [16];
    logic [255:0]  held, exp_row;
    logic [9:0]    addr_before;
    int            nbeat, ndone, errors = 0, checks = 0;

    systolic_output_drain dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .scale(scale), .shift(shift),
        .rd_addr_outbuffer(rd_addr_outbuffer), .rd_data_outbuffer(rd_data_outbuffer),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rd_data_outbuffer <= bmem[rd_addr_outbuffer[3:0]];

    function automatic logic [255:0] rep(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_row(input int r, input logic [31:0] v);
        bmem[r] = {32{v}};
    endtask

    task automatic collect(input int budget, input int stop_beats);
        bit fin = 0;
        nbeat = 0;
        ndone = 0;
        for (int c = 0; c < budget && !fin; c++) begin
            if (out_valid && out_ready) begin
                if (nbeat < 16) begin
                    got[nbeat] = out_data;
                    got_last[nbeat] = out_last;
                end
                nbeat++;
                if (nbeat == stop_beats) fin = 1;
            end
            if (done) begin
                ndone++;
                fin = 1;
            end
            step();
        end
        start = 1'b0;
    endtask

    task automatic run_tile(input int n, input logic [15:0] sc, input logic [4:0] sh);
        num_rows = 10'(n);
        scale = sc;
        shift = sh;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        collect(n + 20, 0);
        chk("tile_done", 256'(ndone), 256'(1));
        chk("tile_beats", 256'(nbeat), 256'(n));
    endtask

    task automatic chk_seq(input int n);
        for (int i = 0; i < n; i++) begin
            chk("seq_data", got[i], rep(8'(i + 1)));
            chk("seq_last", 256'(got_last[i]), 256'(i == n - 1));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) bmem[i] = '0;
        repeat (2) step();
        chk("rst_valid", 256'(out_valid), 256'(0));
        chk("rst_last", 256'(out_last), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_addr", 256'(rd_addr_outbuffer), 256'(0));
        chk("rst_data", out_data, 256'(0));
        rst_n = 1'b1;
        step();

        // full rate: 5, -7, 200 with unity scale
        set_row(0, 32'd5);
        set_row(1, -32'sd7);
        set_row(2, 32'd200);
        num_rows = 10'd3; scale = 16'd1; shift = 5'd0; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("fr_busy_e0", 256'(busy), 256'(1));
        chk("fr_addr_e0", 256'(rd_addr_outbuffer), 256'(0));
        chk("fr_valid_e0", 256'(out_valid), 256'(0));
        step();
        step();
        chk("fr_valid_e2", 256'(out_valid), 256'(0));
        step();
        chk("fr_valid_e3", 256'(out_valid), 256'(1));
        chk("fr_beat0", out_data, rep(8'h05));
        chk("fr_last0", 256'(out_last), 256'(0));
        chk("fr_done0", 256'(done), 256'(0));
        step();
        chk("fr_beat1", out_data, rep(8'hf9));
        chk("fr_last1", 256'(out_last), 256'(0));
        chk("fr_done1", 256'(done), 256'(0));
        step();
        chk("fr_beat2", out_data, rep(8'h7f));
        chk("fr_last2", 256'(out_last), 256'(1));
        chk("fr_done2", 256'(done), 256'(1));
        chk("fr_busy2", 256'(busy), 256'(1));
        step();
        chk("fr_valid_end", 256'(out_valid), 256'(0));
        chk("fr_busy_end", 256'(busy), 256'(0));
        chk("fr_done_end", 256'(done), 256'(0));

        // rounding: even lanes 3, odd lanes -3, scale 1, shift 1 -> 2 / -1
        for (int k = 0; k < 32; k++) bmem[0][k*32 +: 32] = (k % 2 == 0) ? 32'd3 : -32'sd3;
        for (int k = 0; k < 32; k++) exp_row[k*8 +: 8] = (k % 2 == 0) ? 8'h02 : 8'hff;
        run_tile(1, 16'd1, 5'd1);
        chk("rnd_half", got[0], exp_row);
        set_row(0, 32'd100);
        run_tile(1, 16'd3, 5'd4);
        chk("rnd_100x3", got[0], rep(8'h13));
        set_row(0, 32'h8000_0000);
        run_tile(1, 16'd65535, 5'd0);
        chk("sat_neg", got[0], rep(8'h80));

        // backpressure: 8 rows, stalled 10 cycles
        for (int i = 0; i < 8; i++) set_row(i, 32'(i + 1));
        num_rows = 10'd8; scale = 16'd1; shift = 5'd0; out_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        held = out_data;
        chk("bp_head", held, rep(8'h01));
        repeat (5) step();
        chk("bp_stable", out_data, held);
        chk("bp_addr_cap", 256'(rd_addr_outbuffer), 256'(3));
        chk("bp_valid", 256'(out_valid), 256'(1));
        out_ready = 1'b1;
        collect(40, 0);
        chk("bp_done", 256'(ndone), 256'(1));
        chk("bp_beats", 256'(nbeat), 256'(8));
        chk_seq(8);
        chk("bp_addr_end", 256'(rd_addr_outbuffer), 256'(7));

        // zero rows
        addr_before = rd_addr_outbuffer;
        num_rows = 10'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("z_done", 256'(done), 256'(1));
        chk("z_busy", 256'(busy), 256'(0));
        chk("z_valid", 256'(out_valid), 256'(0));
        step();
        chk("z_done_off", 256'(done), 256'(0));
        chk("z_busy2", 256'(busy), 256'(0));
        chk("z_addr", 256'(rd_addr_outbuffer), 256'(addr_before));

        // reset after three rows accepted
        num_rows = 10'd8; scale = 16'd1; shift = 5'd0; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        collect(40, 3);
        chk("rm_beats", 256'(nbeat), 256'(3));
        rst_n = 1'b0;
        #1;
        chk("rm_valid", 256'(out_valid), 256'(0));
        chk("rm_busy", 256'(busy), 256'(0));
        chk("rm_done", 256'(done), 256'(0));
        chk("rm_addr", 256'(rd_addr_outbuffer), 256'(0));
        chk("rm_data", out_data, 256'(0));
        step();
        rst_n = 1'b1;
        step();
        run_tile(2, 16'd1, 5'd0);
        chk_seq(2);

        // start pulses during a drain are ignored, including in the done cycle
        num_rows = 10'd4; scale = 16'd1; shift = 5'd0; out_ready = 1'b1; start = 1'b1;
        step();
        num_rows = 10'd2; scale = 16'd3; shift = 5'd2;
        collect(30, 0);
        chk("ig_done", 256'(ndone), 256'(1));
        chk("ig_beats", 256'(nbeat), 256'(4));
        chk_seq(4);
        chk("ig_busy", 256'(busy), 256'(0));
        step();
        chk("ig_valid_after", 256'(out_valid), 256'(0));
        chk("ig_busy_after", 256'(busy), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
